cycle_steal_arbiter: RTL and testbench

Single-port erasable-memory arbiter between the control-pulse sequencer and the counter-increment ("cycle steal") requests of the AGC build. It serves sequencer reads and writes. It performs PINC/MINC read-modify-write increments of counter cells autonomously, and it guarantees the sequencer one access between any two stolen counter cycles. It sits between the instruction sequencer, the counter/peripheral pulse sources and the erasable memory.

---
 rtl/cycle_steal_arbiter_if.sv | 29 ++
 rtl/cycle_steal_arbiter.sv | 172 +++++++++++++++++
 tb/tb_cycle_steal_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cycle_steal_arbiter_if.sv
// Sequencer request port and single-port memory port of the erasable-memory arbiter.
// The arbiter takes the slave view; the sequencer/memory side takes the master view.
interface cycle_steal_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              seq_req;
    logic              seq_we;
    logic [ADDR_W-1:0] seq_addr;
    logic [DATA_W-1:0] seq_wdata;
    logic              seq_gnt;
    logic              seq_rvalid;
    logic [DATA_W-1:0] seq_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  seq_req, seq_we, seq_addr, seq_wdata, mem_rdata,
        output seq_gnt, seq_rvalid, seq_rdata, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output seq_req, seq_we, seq_addr, seq_wdata, mem_rdata,
        input  seq_gnt, seq_rvalid, seq_rdata, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/cycle_steal_arbiter.sv
// Erasable-memory arbiter: serves sequencer accesses and steals cycles for PINC/MINC
// read-modify-write of counter cells, alternating fairly when both compete.
module cycle_steal_arbiter #(
    parameter int                ADDR_W   = 12,
    parameter int                DATA_W   = 16,
    parameter int                NCNT     = 8,
    parameter logic [ADDR_W-1:0] CNT_BASE = 12'h014
) (
    input  logic                     clk,
    input  logic                     rst_n,
    cycle_steal_arbiter_if.slave     bus,
    input  logic [NCNT-1:0]          cnt_pinc,
    input  logic [NCNT-1:0]          cnt_minc,
    output logic                     cnt_busy,
    output logic                     cnt_drop,
    output logic                     cntr_ovf,
    output logic [$clog2(NCNT)-1:0]  cntr_ovf_idx
);
    localparam int IDX_W = $clog2(NCNT);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEQ_RD = 2'd1;
    localparam logic [1:0] CNT_RD = 2'd2;
    localparam logic [1:0] CNT_WR = 2'd3;

    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MOST_POS = ~MOST_NEG;
    localparam logic [NCNT-1:0]   BIT0     = {{(NCNT-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [NCNT-1:0]   pinc_pend_q, pinc_pend_d;
    logic [NCNT-1:0]   minc_pend_q, minc_pend_d;
    logic              seq_turn_q, seq_turn_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              dir_q, dir_d;   // 1 = PINC, 0 = MINC
    logic              cnt_drop_q, cnt_drop_d;

    logic              any_pend;
    logic              svc_cnt;
    logic              svc_seq;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_dir;
    logic [NCNT-1:0]   clr_pinc;
    logic [NCNT-1:0]   clr_minc;

    assign any_pend = (|pinc_pend_q) | (|minc_pend_q);
    assign svc_cnt  = (state_q == IDLE) && any_pend && (!bus.seq_req || !seq_turn_q);
    assign svc_seq  = (state_q == IDLE) && bus.seq_req && !svc_cnt;

    // Lowest pending index wins; a cell never holds both flags, so PINC-first is implicit.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        pick_idx = '0;
        pick_dir = 1'b0;
        for (int i = NCNT - 1; i >= 0; i--) begin
            if (pinc_pend_q[i] || minc_pend_q[i]) begin
                pick_idx = IDX_W'(i);
                pick_dir = pinc_pend_q[i];
            end
        end
    end

    assign clr_pinc = (svc_cnt &&  pick_dir) ? (BIT0 << pick_idx) : '0;
    assign clr_minc = (svc_cnt && !pick_dir) ? (BIT0 << pick_idx) : '0;

    // Service clears first, so a same-cycle pulse on the serviced cell re-arms it.
    always_comb begin
        pinc_pend_d = pinc_pend_q & ~clr_pinc;
        minc_pend_d = minc_pend_q & ~clr_minc;
        cnt_drop_d  = 1'b0;
        for (int i = 0; i < NCNT; i++) begin
            if (cnt_pinc[i] && !cnt_minc[i]) begin
                if (minc_pend_d[i]) begin
                    minc_pend_d[i] = 1'b0;
                end else begin
                    cnt_drop_d     = cnt_drop_d | pinc_pend_d[i];
                    pinc_pend_d[i] = 1'b1;
                end
            end else if (cnt_minc[i] && !cnt_pinc[i]) begin
                if (pinc_pend_d[i]) begin
                    pinc_pend_d[i] = 1'b0;
                end else begin
                    cnt_drop_d     = cnt_drop_d | minc_pend_d[i];
                    minc_pend_d[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        seq_turn_d = seq_turn_q;
        result_d   = result_q;
        idx_d      = idx_q;
        dir_d      = dir_q;
        case (state_q)
            IDLE: begin
                if (svc_cnt) begin
                    idx_d   = pick_idx;
                    dir_d   = pick_dir;
                    state_d = CNT_RD;
                end else if (svc_seq) begin
                    seq_turn_d = 1'b0;
                    if (!bus.seq_we) state_d = SEQ_RD;
                end
            end
            SEQ_RD: state_d = IDLE;
            CNT_RD: begin
                result_d = dir_q ? (bus.mem_rdata + DATA_W'(1)) : (bus.mem_rdata - DATA_W'(1));
                state_d  = CNT_WR;
            end
            CNT_WR: begin
                seq_turn_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        if (svc_cnt) begin
            bus.mem_addr = CNT_BASE + ADDR_W'(pick_idx);
        end else if (svc_seq) begin
            bus.mem_addr  = bus.seq_addr;
            bus.mem_we    = bus.seq_we;
            bus.mem_wdata = bus.seq_we ? bus.seq_wdata : '0;
        end else if (state_q == CNT_WR) begin
            bus.mem_addr  = CNT_BASE + ADDR_W'(idx_q);
            bus.mem_we    = 1'b1;
            bus.mem_wdata = result_q;
        end
    end

    assign bus.seq_gnt    = svc_seq;
    assign bus.seq_rvalid = (state_q == SEQ_RD);
    assign bus.seq_rdata  = (state_q == SEQ_RD) ? bus.mem_rdata : '0;

    // Overflow is the signed wrap of the written-back value, seen only in CNT_WR.
    assign cntr_ovf     = (state_q == CNT_WR) &&
                          (dir_q ? (result_q == MOST_NEG) : (result_q == MOST_POS));
    assign cntr_ovf_idx = cntr_ovf ? idx_q : '0;
    assign cnt_drop     = cnt_drop_q;
    assign cnt_busy     = any_pend || (state_q == CNT_RD) || (state_q == CNT_WR);

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked block and aborts any RMW.
        if (!rst_n) begin
            state_q     <= IDLE;
            pinc_pend_q <= '0;
            minc_pend_q <= '0;
            seq_turn_q  <= 1'b0;
            result_q    <= '0;
            idx_q       <= '0;
            dir_q       <= 1'b0;
            cnt_drop_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every flop sampling pre-edge values.
            state_q     <= state_d;
            pinc_pend_q <= pinc_pend_d;
            minc_pend_q <= minc_pend_d;
            seq_turn_q  <= seq_turn_d;
            result_q    <= result_d;
            idx_q       <= idx_d;
            dir_q       <= dir_d;
            cnt_drop_q  <= cnt_drop_d;
        end
    end
endmodule

// File: tb/tb_cycle_steal_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, checked by a
// scoreboard against a net-pending-count model of each counter cell.
module tb_cycle_steal_arbiter;
    localparam int          ADDR_W   = 12;
    localparam int          DATA_W   = 16;
    localparam int          NCNT     = 8;
    localparam logic [11:0] CNT_BASE = 12'h014;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] cnt_pinc = '0;
    logic [7:0] cnt_minc = '0;
    logic       cnt_busy;
    logic       cnt_drop;
    logic       cntr_ovf;
    logic [2:0] cntr_ovf_idx;

    cycle_steal_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    cycle_steal_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NCNT(NCNT), .CNT_BASE(CNT_BASE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .cnt_pinc     (cnt_pinc),
        .cnt_minc     (cnt_minc),
        .cnt_busy     (cnt_busy),
        .cnt_drop     (cnt_drop),
        .cntr_ovf     (cntr_ovf),
        .cntr_ovf_idx (cntr_ovf_idx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem     [0:4095];
    logic [15:0] ref_mem [0:4095];

    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    typedef struct {
        logic [11:0] addr;
        logic [15:0] old_val;
        logic [15:0] new_val;
        logic        ovf;
        logic [2:0]  idx;
    } rmw_t;

    logic [15:0] seq_exp_q[$];
    rmw_t        rmw_q[$];
    int          pend[NCNT];     // net pending change per counter: -1, 0 or +1
    int          rmw_left = 0;
    logic        drop_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model and monitor: sampled mid-cycle, once DUT outputs settle.
    rmw_t mon_e;
    logic busy_exp;
    logic drop_now;
    int   lowest;
    int   sidx;
    int   dirv;
    always @(negedge clk) begin
        if (!rst_n) begin
            while (rmw_q.size() > 0) begin
                mon_e = rmw_q.pop_back();
                ref_mem[mon_e.addr] = mon_e.old_val;
            end
            foreach (pend[i]) pend[i] = 0;
            rmw_left  = 0;
            drop_prev = 1'b0;
        end else begin
            busy_exp = (rmw_left > 0);
            foreach (pend[i]) if (pend[i] != 0) busy_exp = 1'b1;
            check("cnt_busy", 32'(cnt_busy), 32'(busy_exp));
            check("cnt_drop", 32'(cnt_drop), 32'(drop_prev));
            if (rmw_left > 0) rmw_left--;

            if (bus.seq_rvalid === 1'b1) begin
                if (seq_exp_q.size() == 0) check("seq_rvalid_unexpected", 32'(bus.seq_rvalid), 0);
                else check("seq_rdata", 32'(bus.seq_rdata), 32'(seq_exp_q.pop_front()));
            end

            if (bus.mem_we === 1'b1 && bus.seq_gnt !== 1'b1) begin
                if (rmw_q.size() == 0) begin
                    check("cnt_write_unexpected", 32'(bus.mem_we), 0);
                end else begin
                    mon_e = rmw_q.pop_front();
                    check("cnt_wr_addr", 32'(bus.mem_addr), 32'(mon_e.addr));
                    check("cnt_wr_data", 32'(bus.mem_wdata), 32'(mon_e.new_val));
                    check("cntr_ovf", 32'(cntr_ovf), 32'(mon_e.ovf));
                    if (mon_e.ovf) check("cntr_ovf_idx", 32'(cntr_ovf_idx), 32'(mon_e.idx));
                end
            end else if (cntr_ovf !== 1'b0) begin
                check("cntr_ovf_spurious", 32'(cntr_ovf), 0);
            end

            if (bus.mem_we === 1'b0 && bus.seq_gnt === 1'b0 &&
                bus.mem_addr >= CNT_BASE && bus.mem_addr < CNT_BASE + 12'(NCNT)) begin
                lowest = -1;
                for (int i = NCNT - 1; i >= 0; i--) if (pend[i] != 0) lowest = i;
                sidx = int'(bus.mem_addr - CNT_BASE);
                check("svc_idx", 32'(sidx), 32'(lowest));
                if (pend[sidx] != 0) begin
                    mon_e.addr    = bus.mem_addr;
                    mon_e.old_val = ref_mem[bus.mem_addr];
                    mon_e.new_val = mon_e.old_val + 16'(pend[sidx]);
                    mon_e.ovf     = (pend[sidx] == 1 && mon_e.old_val == 16'h7FFF) ||
                                    (pend[sidx] == -1 && mon_e.old_val == 16'h8000);
                    mon_e.idx     = 3'(sidx);
                    ref_mem[bus.mem_addr] = mon_e.new_val;
                    rmw_q.push_back(mon_e);
                end
                pend[sidx] = 0;
                rmw_left   = 2;
            end

            drop_now = 1'b0;
            for (int i = 0; i < NCNT; i++) begin
                if (cnt_pinc[i] != cnt_minc[i]) begin
                    dirv = cnt_pinc[i] ? 1 : -1;
                    if (pend[i] == -dirv)     pend[i] = 0;
                    else if (pend[i] == dirv) drop_now = 1'b1;
                    else                      pend[i] = dirv;
                end
            end
            drop_prev = drop_now;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic seq_access(input logic we, input logic [11:0] a, input logic [15:0] d,
                              output logic [15:0] rd, output int waited);
        tick();
        bus.seq_req   = 1'b1;
        bus.seq_we    = we;
        bus.seq_addr  = a;
        bus.seq_wdata = d;
        if (we) ref_mem[a] = d;
        else    seq_exp_q.push_back(ref_mem[a]);
        waited = 0;
        rd     = '0;
        @(negedge clk);
        while (bus.seq_gnt !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("seq_gnt", 32'(bus.seq_gnt), 1);
        check("seq_mem_we", 32'(bus.mem_we), 32'(we));
        tick();
        bus.seq_req = 1'b0;
        bus.seq_we  = 1'b0;
        if (!we) begin
            @(negedge clk);
            check("seq_rvalid", 32'(bus.seq_rvalid), 1);
            rd = bus.seq_rdata;
        end
    endtask

    logic [15:0] rd;
    int          waited;
    int          code;
    logic        got_gnt;
    logic        seen_we;
    logic        seen_busy;
    int          drops;
    int          k;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        bus.seq_req   = 1'b0;
        bus.seq_we    = 1'b0;
        bus.seq_addr  = '0;
        bus.seq_wdata = '0;

        // Reset with pulses that must be discarded.
        repeat (2) begin
            tick();
            cnt_pinc = 8'hFF;
        end
        tick();
        rst_n    = 1'b1;
        cnt_pinc = '0;
        @(negedge clk);
        check("rst_seq", {bus.seq_gnt, bus.seq_rvalid, bus.seq_rdata}, 0);
        check("rst_cnt", {cnt_busy, cnt_drop, cntr_ovf, cntr_ovf_idx}, 0);
        check("rst_mem_ctl", {bus.mem_we, bus.mem_addr}, 0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 0);
        seen_we = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen_we |= bus.mem_we;
        end
        check("rst_no_write", 32'(seen_we), 0);

        // Sequencer write then read.
        seq_access(1'b1, 12'h100, 16'h1234, rd, waited);
        check("seq_wr_wait", 32'(waited), 0);
        seq_access(1'b0, 12'h100, 16'h0000, rd, waited);
        check("seq_rd_data", 32'(rd), 32'h1234);

        // Counter wrap on counter 2.
        seq_access(1'b1, 12'h016, 16'h7FFF, rd, waited);
        tick(); cnt_pinc = 8'h04;
        tick(); cnt_pinc = 8'h00;
        @(negedge clk);
        check("wrap_issue", {bus.mem_we, bus.mem_addr}, {1'b0, 12'h016});
        @(negedge clk);
        @(negedge clk);
        check("wrap_wr", {bus.mem_we, bus.mem_wdata, cntr_ovf, cntr_ovf_idx}, {1'b1, 16'h8000, 1'b1, 3'd2});
        @(negedge clk);
        check("wrap_busy_fall", 32'(cnt_busy), 0);
        seq_access(1'b0, 12'h016, 16'h0000, rd, waited);
        check("wrap_readback", 32'(rd), 32'h8000);

        // Fairness: two counters pending against a held sequencer read.
        seq_access(1'b1, 12'h050, 16'hBEEF, rd, waited);
        tick(); cnt_pinc = 8'h03;
        tick(); cnt_pinc = 8'h00;
        bus.seq_req  = 1'b1;
        bus.seq_we   = 1'b0;
        bus.seq_addr = 12'h050;
        seq_exp_q.push_back(ref_mem[12'h050]);
        code    = 0;
        got_gnt = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.seq_gnt === 1'b1) begin
                code    = code * 16 + 2;
                got_gnt = 1'b1;
            end else if (bus.mem_we === 1'b0 && bus.mem_addr == 12'h014) code = code * 16 + 1;
            else if (bus.mem_we === 1'b0 && bus.mem_addr == 12'h015) code = code * 16 + 3;
            tick();
            if (got_gnt) bus.seq_req = 1'b0;
        end
        check("fair_order", 32'(code), 32'h123);
        seq_access(1'b0, 12'h014, 16'h0000, rd, waited);
        check("fair_cnt0", 32'(rd), 32'h0001);
        seq_access(1'b0, 12'h015, 16'h0000, rd, waited);
        check("fair_cnt1", 32'(rd), 32'h0001);

        // Cancel: simultaneous opposite pulses are ignored.
        tick(); cnt_pinc = 8'h08; cnt_minc = 8'h08;
        tick(); cnt_pinc = 8'h00; cnt_minc = 8'h00;
        seen_we   = 1'b0;
        seen_busy = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen_we   |= bus.mem_we;
            seen_busy |= cnt_busy;
        end
        check("cancel_same_cycle", {seen_we, seen_busy}, 0);

        // Cancel: MINC then PINC on counter 4 while counter 0 holds the memory.
        tick(); cnt_pinc = 8'h01;
        tick(); cnt_pinc = 8'h00; cnt_minc = 8'h10;
        tick(); cnt_minc = 8'h00; cnt_pinc = 8'h10;
        tick(); cnt_pinc = 8'h00;
        repeat (4) tick();
        seq_access(1'b0, 12'h018, 16'h0000, rd, waited);
        check("cancel_cnt4", 32'(rd), 32'h0000);

        // Merge: second PINC on counter 5 while the first is still pending.
        tick(); cnt_pinc = 8'h01;
        tick(); cnt_pinc = 8'h20;
        tick(); cnt_pinc = 8'h20;
        tick(); cnt_pinc = 8'h00;
        drops = 0;
        repeat (8) begin
            @(negedge clk);
            if (cnt_drop === 1'b1) drops++;
        end
        check("merge_drops", 32'(drops), 1);
        seq_access(1'b0, 12'h019, 16'h0000, rd, waited);
        check("merge_cnt5", 32'(rd), 32'h0001);

        // Random mixed traffic; the scoreboard checks everything.
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    tick();
                    cnt_pinc = '0;
                    cnt_minc = '0;
                    for (int i = 0; i < NCNT; i++) begin
                        cnt_pinc[i] = ($urandom_range(0, 11) == 0);
                        cnt_minc[i] = ($urandom_range(0, 11) == 0);
                    end
                end
                tick();
                cnt_pinc = '0;
                cnt_minc = '0;
            end
            begin
                logic [15:0] r_rd;
                int          r_wait;
                for (int n = 0; n < 60; n++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    seq_access(1'($urandom_range(0, 1)), 12'h100 + 12'($urandom_range(0, 15)),
                               16'($urandom), r_rd, r_wait);
                    check("rand_seq_wait", 32'(r_wait <= 3), 1);
                end
            end
        join

        k = 0;
        @(negedge clk);
        while (cnt_busy !== 1'b0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("drain_busy", 32'(cnt_busy), 0);
        for (int i = 0; i < NCNT; i++) seq_access(1'b0, CNT_BASE + 12'(i), 16'h0000, rd, waited);
        repeat (3) @(negedge clk);
        check("seq_queue_empty", 32'(seq_exp_q.size()), 0);
        check("rmw_queue_empty", 32'(rmw_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "timeout");
    end
endmodule
